// File: rtl/mesm6_busctl.sv
// MESM-6 data-port bus controller: RAM window plus NDEV I/O slots,
// handshake transactions with a timeout watchdog, and IRQ registering.
module mesm6_busctl #(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [14:0]       cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [47:0]       cpu_wdata,
    output logic [47:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [14:0]       mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [47:0]       mem_wdata,
    input  logic [47:0]       mem_rdata,
    input  logic              mem_done,
    output logic [14:0]       dev_addr,
    output logic [47:0]       dev_wdata,
    output logic [NDEV-1:0]   dev_read,
    output logic [NDEV-1:0]   dev_write,
    input  logic [NDEV*48-1:0] dev_rdata,
    input  logic [NDEV-1:0]   dev_done,
    input  logic [NDEV-1:0]   dev_int,
    output logic [47:0]       pic_irq
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [11:0] TO12 = 12'(TIMEOUT);

    state_t            state;
    state_t            state_n;
    logic [14:0]       addr_q;
    logic [47:0]       wdata_q;
    logic              rd_q;
    logic              tgt_mem;
    logic [NDEV-1:0]   tgt_dev;
    logic [11:0]       cnt;
    logic              err_q;

    logic [NDEV-1:0]   slot_hit;
    logic              io_page;
    logic              hole;
    logic              tgt_done;
    logic [47:0]       tgt_rdata;
    logic              accept_ok;
    logic              accept_err;
    logic              fin_ok;
    logic              fin_to;

    // Slots sit downward from the very top of the I/O page.
    always_comb begin
        slot_hit = '0;
        for (int k = 0; k < NDEV; k++) begin
            slot_hit[k] = (cpu_addr[14:3] == 12'(12'o7777 - k));
        end
    end

    assign io_page = (cpu_addr[14:9] == 6'o77);
    assign hole    = io_page && (slot_hit == '0);

    always_comb begin
        tgt_done  = tgt_mem ? mem_done : 1'b0;
        tgt_rdata = tgt_mem ? mem_rdata : 48'd0;
        for (int k = 0; k < NDEV; k++) begin
            if (tgt_dev[k]) begin
                tgt_done  = dev_done[k];
                tgt_rdata = dev_rdata[48*k +: 48];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        accept_ok  = 1'b0;
        accept_err = 1'b0;
        fin_ok     = 1'b0;
        fin_to     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_read && cpu_write) begin
                    accept_err = 1'b1;
                    state_n    = DONE;
                end else if (cpu_read || cpu_write) begin
                    if (hole) begin
                        accept_err = 1'b1;
                        state_n    = DONE;
                    end else begin
                        accept_ok = 1'b1;
                        state_n   = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A done arriving on the timeout cycle still wins.
                if (tgt_done) begin
                    fin_ok  = 1'b1;
                    state_n = DONE;
                end else if (cnt + 12'd1 == TO12) begin
                    fin_to  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            tgt_mem   <= 1'b0;
            tgt_dev   <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            cpu_rdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            dev_read  <= '0;
            dev_write <= '0;
            pic_irq   <= '0;
        end else begin
            pic_irq <= 48'(dev_int);
            if (accept_ok) begin
                addr_q    <= cpu_addr;
                wdata_q   <= cpu_wdata;
                rd_q      <= cpu_read;
                tgt_mem   <= !io_page;
                tgt_dev   <= io_page ? slot_hit : '0;
                cnt       <= '0;
                mem_read  <= !io_page && cpu_read;
                mem_write <= !io_page && cpu_write;
                dev_read  <= (io_page && cpu_read) ? slot_hit : '0;
                dev_write <= (io_page && cpu_write) ? slot_hit : '0;
            end
            if (accept_err) begin
                err_q     <= 1'b1;
                cpu_rdata <= '0;
            end
            if (state == ACCESS) begin
                cnt <= cnt + 12'd1;
            end
            if (fin_ok) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                dev_read  <= '0;
                dev_write <= '0;
                err_q     <= 1'b0;
                cpu_rdata <= rd_q ? tgt_rdata : 48'd0;
            end
            if (fin_to) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                dev_read  <= '0;
                dev_write <= '0;
                err_q     <= 1'b1;
                cpu_rdata <= '0;
            end
        end
    end

    assign cpu_done  = (state == DONE);
    assign cpu_err   = err_q && (state == DONE);
    assign mem_addr  = addr_q;
    assign dev_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dev_wdata = wdata_q;

endmodule
